// File: rtl/axi4_sram_if.sv
// ----------------------------------------------------------------------------
// axi4_if : AXI4 bus bundle (AW/W/B/AR/R) used between an interconnect
// slave port and a memory slave.
//
// Parameters
//   ADDR_WIDTH : address width
//   DATA_WIDTH : data width (WSTRB is DATA_WIDTH/8 bits)
//   ID_WIDTH   : transaction ID width
//
// Modports
//   master : drives AW/W/AR valid+payload, BREADY, RREADY
//   slave  : drives AWREADY, WREADY, ARREADY, the B channel and the R channel
// ----------------------------------------------------------------------------
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    // Write address channel
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // Write response channel
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // Read address channel
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;
    // Read data channel
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi4_sram.sv
// ----------------------------------------------------------------------------
// axi4_sram : AXI4 slave memory serving FIXED, INCR and WRAP bursts from an
// internal word array. One transaction (read or write) is in flight at a
// time; when AW and AR arrive together the channel holding priority wins and
// priority passes to the other channel. Priority starts with writes.
//
// Ports
//   clk : clock
//   rst : synchronous, active-high reset (memory contents are kept)
//   s   : axi4_if.slave port (AW/W/B/AR/R)
//
// Optional feature (compile-time macro AXI4_SRAM_RANGE_CHECK_EN):
//   defined   - beats whose word index is >= MEM_WORDS are not written and
//               read back as 0; the read beat reports SLVERR and a write burst
//               with any such beat reports SLVERR on B. MEM_WORDS may then be
//               any size.
//   undefined - the word index simply wraps modulo the array (MEM_WORDS must
//               be a power of two) and every response is OKAY.
// ----------------------------------------------------------------------------
module axi4_sram #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH      = 4,
    parameter int MEM_WORDS          = 4096
) (
    input logic   clk,
    input logic   rst,
    axi4_if.slave s
);
    localparam int AW     = AXI4_ADDRESS_WIDTH;
    localparam int DW     = AXI4_DATA_WIDTH;
    localparam int IW     = AXI4_ID_WIDTH;
    localparam int STRB_W = DW / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_WORDS);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_DATA
    } state_t;

    // ------------------------------------------------------------------------
    // Address helpers
    // ------------------------------------------------------------------------
    // Address of the beat following 'a'. SIZE beyond the bus width counts as
    // full width. WRAP keeps the address inside an aligned (LEN+1)*bytes
    // container; INCR past the top of the array wraps via index truncation.
    function automatic logic [AW-1:0] next_addr(
        input logic [AW-1:0] a,
        input logic [7:0]    len,
        input logic [2:0]    size,
        input logic [1:0]    burst
    );
        logic [2:0]    eff_size;
        logic [AW-1:0] bytes;
        logic [AW-1:0] inc;
        logic [AW-1:0] container;
        logic [AW-1:0] mask;
        eff_size  = (size > 3'(LSB)) ? 3'(LSB) : size;
        bytes     = AW'(1) << eff_size;
        inc       = a + bytes;
        container = bytes * (AW'(len) + AW'(1));
        mask      = container - AW'(1);
        case (burst)
            BURST_FIXED: next_addr = a;
            BURST_WRAP:  next_addr = (a & ~mask) | (inc & mask);
            default:     next_addr = inc;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        word_idx = IDX_W'(a >> LSB);
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t state;
    state_t state_next;
    logic   prio_rd;        // 1: reads win the next AW/AR collision

    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_len;
    logic [2:0]    wr_size;
    logic [1:0]    wr_burst;
    logic [IW-1:0] wr_id;
    logic [7:0]    wr_beat;
    logic          wr_err;

    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_len;
    logic [2:0]    rd_size;
    logic [1:0]    rd_burst;
    logic [IW-1:0] rd_id;
    logic [7:0]    rd_beat;
    logic [DW-1:0] rdata_q;
    logic [1:0]    rresp_q;

    logic [DW-1:0] mem [MEM_WORDS];

    // Handshake / control
    logic aw_win;
    logic ar_win;
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    logic r_valid;
    logic r_last;
    logic w_fire;
    logic r_fire;

    logic [AW-1:0]    wr_next;
    logic [AW-1:0]    rd_next;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] ar_idx;
    logic [IDX_W-1:0] rd_next_idx;
    logic             wr_ok;
    logic             ar_ok;
    logic             rd_next_ok;

    // Termination is counted by beats, so WLAST is deliberately ignored.
    logic unused_wlast;
    assign unused_wlast = s.wlast;

    assign wr_next     = next_addr(wr_addr, wr_len, wr_size, wr_burst);
    assign rd_next     = next_addr(rd_addr, rd_len, rd_size, rd_burst);
    assign wr_idx      = word_idx(wr_addr);
    assign ar_idx      = word_idx(s.araddr);
    assign rd_next_idx = word_idx(rd_next);

`ifdef AXI4_SRAM_RANGE_CHECK_EN
    function automatic logic in_range(input logic [AW-1:0] a);
        in_range = (a >> LSB) < AW'(MEM_WORDS);
    endfunction

    assign wr_ok      = in_range(wr_addr);
    assign ar_ok      = in_range(s.araddr);
    assign rd_next_ok = in_range(rd_next);
`else
    assign wr_ok      = 1'b1;
    assign ar_ok      = 1'b1;
    assign rd_next_ok = 1'b1;
`endif

    // Arbiter: a lone request wins; on a collision the priority holder wins.
    assign aw_win = s.awvalid && (!s.arvalid || !prio_rd);
    assign ar_win = s.arvalid && !aw_win;

    assign w_fire = w_ready && s.wvalid;
    assign r_fire = r_valid && s.rready;

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        aw_ready   = 1'b0;
        ar_ready   = 1'b0;
        w_ready    = 1'b0;
        b_valid    = 1'b0;
        r_valid    = 1'b0;
        r_last     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    aw_ready = aw_win;
                    ar_ready = ar_win;
                    if (aw_win) begin
                        state_next = WR_DATA;
                    end else if (ar_win) begin
                        state_next = RD_DATA;
                    end
                end
                WR_DATA: begin
                    w_ready = 1'b1;
                    if (s.wvalid && (wr_beat == wr_len)) begin
                        state_next = WR_RESP;
                    end
                end
                WR_RESP: begin
                    b_valid = 1'b1;
                    if (s.bready) begin
                        state_next = IDLE;
                    end
                end
                RD_DATA: begin
                    r_valid = 1'b1;
                    r_last  = (rd_beat == rd_len);
                    if (s.rready && r_last) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_rd  <= 1'b0;
            wr_addr  <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_id    <= '0;
            wr_beat  <= '0;
            wr_err   <= 1'b0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_id    <= '0;
            rd_beat  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (aw_ready) begin
                wr_addr  <= s.awaddr;
                wr_len   <= s.awlen;
                wr_size  <= s.awsize;
                wr_burst <= s.awburst;
                wr_id    <= s.awid;
                wr_beat  <= '0;
                wr_err   <= 1'b0;
                if (s.arvalid) begin
                    prio_rd <= 1'b1;
                end
            end

            if (ar_ready) begin
                rd_addr  <= s.araddr;
                rd_len   <= s.arlen;
                rd_size  <= s.arsize;
                rd_burst <= s.arburst;
                rd_id    <= s.arid;
                rd_beat  <= '0;
                rdata_q  <= ar_ok ? mem[ar_idx] : '0;
                rresp_q  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                if (s.awvalid) begin
                    prio_rd <= 1'b0;
                end
            end

            if (w_fire) begin
                wr_addr <= wr_next;
                wr_beat <= wr_beat + 8'd1;
                if (!wr_ok) begin
                    wr_err <= 1'b1;
                end
            end

            // Prefetch the next beat on each accepted beat so RDATA is ready
            // the following cycle; a stalled beat leaves everything untouched.
            if (r_fire && !r_last) begin
                rd_addr <= rd_next;
                rd_beat <= rd_beat + 8'd1;
                rdata_q <= rd_next_ok ? mem[rd_next_idx] : '0;
                rresp_q <= rd_next_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------------
    // NOTE: the array has no reset; clearing it would force a flop
    // implementation, and its contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (!rst && w_fire && wr_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s.wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= s.wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Port outputs
    // ------------------------------------------------------------------------
    assign s.awready = aw_ready;
    assign s.arready = ar_ready;
    assign s.wready  = w_ready;
    assign s.bvalid  = b_valid;
    assign s.bid     = wr_id;
    assign s.bresp   = wr_err ? RESP_SLVERR : RESP_OKAY;
    assign s.rvalid  = r_valid;
    assign s.rlast   = r_last;
    assign s.rid     = rd_id;
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_sram.sv
// ----------------------------------------------------------------------------
// tb_axi4_sram : self-checking bench for axi4_sram. Expected B and R beats are
// queued when a transaction is issued and compared by a monitor as the DUT
// hands them over. Inputs change 1 time unit after posedge; outputs are
// sampled on negedge.
// ----------------------------------------------------------------------------
module tb_axi4_sram;
    localparam int DW = 32;
    localparam int IW = 4;
`ifdef AXI4_SRAM_RANGE_CHECK_EN
    localparam int MW = 1000;
`else
    localparam int MW = 4096;
`endif

    localparam logic [1:0] FIXED  = 2'b00;
    localparam logic [1:0] INCR   = 2'b01;
    localparam logic [1:0] WRAP   = 2'b10;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    axi4_sram #(
        .AXI4_ADDRESS_WIDTH(32),
        .AXI4_DATA_WIDTH   (DW),
        .AXI4_ID_WIDTH     (IW),
        .MEM_WORDS         (MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s  (bus)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [IW-1:0] id;
    } r_exp_t;

    typedef struct {
        logic [IW-1:0] id;
        logic [1:0]    resp;
    } b_exp_t;

    r_exp_t        r_q[$];
    r_exp_t        stage_q[$];
    b_exp_t        b_q[$];
    logic [DW-1:0] wq[$];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Monitor: B/R scoreboard plus R stability under backpressure
    // ------------------------------------------------------------------------
    r_exp_t        re;
    b_exp_t        be;
    logic          stall_prev = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("r_hold_valid", bus.rvalid, 1);
                check("r_hold_data", bus.rdata, stall_data);
                check("r_hold_last", bus.rlast, stall_last);
            end
            stall_prev = bus.rvalid && !bus.rready;
            stall_data = bus.rdata;
            stall_last = bus.rlast;

            if (bus.rvalid && bus.rready) begin
                if (r_q.size() == 0) begin
                    check("r_unexpected", 1, 0);
                end else begin
                    re = r_q.pop_front();
                    check("rdata", bus.rdata, re.data);
                    check("rresp", bus.rresp, re.resp);
                    check("rlast", bus.rlast, re.last);
                    check("rid", bus.rid, re.id);
                end
            end

            if (bus.bvalid && bus.bready) begin
                if (b_q.size() == 0) begin
                    check("b_unexpected", 1, 0);
                end else begin
                    be = b_q.pop_front();
                    check("bid", bus.bid, be.id);
                    check("bresp", bus.bresp, be.resp);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks (entered and left at posedge + 1)
    // ------------------------------------------------------------------------
    task automatic aw_hs(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int   n;
        logic got;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk); got = bus.awready;
            @(posedge clk); #1; n++;
        end
        bus.awvalid = 1'b0;
        check("aw_accepted", got, 1);
    endtask

    task automatic w_hs(input logic [DW-1:0] data, input logic [3:0] strb, input logic last);
        int   n;
        logic got;
        bus.wdata = data; bus.wstrb = strb; bus.wlast = last; bus.wvalid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk); got = bus.wready;
            @(posedge clk); #1; n++;
        end
        bus.wvalid = 1'b0;
        check("w_accepted", got, 1);
    endtask

    // Also checks that RVALID rises exactly one cycle after the AR handshake.
    task automatic ar_hs(input logic [IW-1:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int   n;
        logic got;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 50) begin
            @(negedge clk); got = bus.arready;
            if (got) check("rvalid_at_ar", bus.rvalid, 0);
            @(posedge clk); #1; n++;
        end
        bus.arvalid = 1'b0;
        check("ar_accepted", got, 1);
        @(negedge clk);
        check("rvalid_latency", bus.rvalid, 1);
        @(posedge clk); #1;
    endtask

    task automatic rexp(input logic [DW-1:0] data, input logic [1:0] resp);
        r_exp_t e;
        e.data = data; e.resp = resp; e.last = 1'b0; e.id = '0;
        stage_q.push_back(e);
    endtask

    task automatic commit_r(input logic [IW-1:0] id);
        int n;
        n = stage_q.size();
        for (int i = 0; i < n; i++) begin
            r_exp_t e;
            e = stage_q.pop_front();
            e.id   = id;
            e.last = (i == n - 1);
            r_q.push_back(e);
        end
    endtask

    task automatic wait_b();
        int n;
        n = 0;
        while (b_q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("b_done", b_q.size(), 0);
    endtask

    task automatic wait_r(input bit toggle);
        int n;
        bit phase;
        n = 0; phase = 1'b0;
        while (r_q.size() != 0 && n < 64) begin
            if (toggle) begin
                bus.rready = phase;
                phase = !phase;
            end
            @(posedge clk); #1; n++;
        end
        bus.rready = 1'b1;
        check("r_done", r_q.size(), 0);
    endtask

    task automatic wr_burst(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [3:0] strb, input logic [1:0] bresp);
        b_exp_t e;
        e.id = id; e.resp = bresp;
        b_q.push_back(e);
        aw_hs(id, addr, len, 3'd2, burst);
        for (int i = 0; i <= int'(len); i++) begin
            w_hs(wq.pop_front(), strb, i == int'(len));
        end
        wait_b();
    endtask

    task automatic rd_burst(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input bit toggle);
        commit_r(id);
        ar_hs(id, addr, len, size, burst);
        wait_r(toggle);
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b_exp_t bx;
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        bus.bready = 1; bus.rready = 1;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_awready", bus.awready, 0);
        check("rst_arready", bus.arready, 0);
        check("rst_wready", bus.wready, 0);
        check("rst_bvalid", bus.bvalid, 0);
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_rlast", bus.rlast, 0);
        check("rst_bresp", bus.bresp, 0);
        check("rst_rresp", bus.rresp, 0);
        check("rst_rdata", bus.rdata, 0);
        check("rst_bid", bus.bid, 0);
        check("rst_rid", bus.rid, 0);
        @(posedge clk); #1;

        // Collision from reset: write wins, read follows.
        bx.id = 4'd1; bx.resp = OKAY; b_q.push_back(bx);
        rexp(32'hCAFE_0001, OKAY); commit_r(4'd2);
        bus.arid = 4'd2; bus.araddr = 32'h400; bus.arlen = 0; bus.arsize = 2; bus.arburst = INCR;
        bus.arvalid = 1'b1;
        bus.awid = 4'd1; bus.awaddr = 32'h400; bus.awlen = 0; bus.awsize = 2; bus.awburst = INCR;
        bus.awvalid = 1'b1;
        @(negedge clk);
        check("arb1_awready", bus.awready, 1);
        check("arb1_arready", bus.arready, 0);
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        w_hs(32'hCAFE_0001, 4'hF, 1'b1);
        ar_hs(4'd2, 32'h400, 0, 2, INCR);
        wait_b();
        wait_r(0);

        // Second collision: priority has moved to reads.
        wq.push_back(32'h0000_AAAA);
        wr_burst(4'd3, 32'h404, 0, INCR, 4'hF, OKAY);
        bx.id = 4'd5; bx.resp = OKAY; b_q.push_back(bx);
        rexp(32'h0000_AAAA, OKAY); commit_r(4'd4);
        bus.arid = 4'd4; bus.araddr = 32'h404; bus.arlen = 0; bus.arsize = 2; bus.arburst = INCR;
        bus.arvalid = 1'b1;
        bus.awid = 4'd5; bus.awaddr = 32'h404; bus.awlen = 0; bus.awsize = 2; bus.awburst = INCR;
        bus.awvalid = 1'b1;
        @(negedge clk);
        check("arb2_arready", bus.arready, 1);
        check("arb2_awready", bus.awready, 0);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        aw_hs(4'd5, 32'h404, 0, 2, INCR);
        w_hs(32'h0000_BBBB, 4'hF, 1'b1);
        wait_b();
        wait_r(0);
        rexp(32'h0000_BBBB, OKAY);
        rd_burst(4'd6, 32'h404, 0, 2, INCR, 0);

        // Single write then read
        wq.push_back(32'hDEAD_BEEF);
        wr_burst(4'd7, 32'h100, 0, INCR, 4'hF, OKAY);
        rexp(32'hDEAD_BEEF, OKAY);
        rd_burst(4'd8, 32'h100, 0, 2, INCR, 0);

        // INCR 4-beat, read back with RREADY toggling
        for (int i = 1; i <= 4; i++) wq.push_back(DW'(i));
        wr_burst(4'd9, 32'h200, 3, INCR, 4'hF, OKAY);
        for (int i = 1; i <= 4; i++) rexp(DW'(i), OKAY);
        rd_burst(4'd10, 32'h200, 3, 2, INCR, 1);

        // WRAP read starting mid-container
        for (int i = 0; i < 4; i++) wq.push_back(32'hA0 + DW'(i));
        wr_burst(4'd11, 32'h200, 3, INCR, 4'hF, OKAY);
        rexp(32'hA2, OKAY); rexp(32'hA3, OKAY); rexp(32'hA0, OKAY); rexp(32'hA1, OKAY);
        rd_burst(4'd12, 32'h208, 3, 2, WRAP, 0);

        // Oversized SIZE behaves as full width
        rexp(32'hA0, OKAY); rexp(32'hA1, OKAY);
        rd_burst(4'd13, 32'h200, 1, 3'd3, INCR, 0);

        // Byte strobes
        wq.push_back(32'h1122_3344);
        wr_burst(4'd14, 32'h300, 0, INCR, 4'hF, OKAY);
        wq.push_back(32'hFFFF_FFFF);
        wr_burst(4'd15, 32'h300, 0, INCR, 4'h5, OKAY);
        rexp(32'h11FF_33FF, OKAY);
        rd_burst(4'd0, 32'h300, 0, 2, INCR, 0);

        // FIXED bursts hit one word
        wq.push_back(32'h5); wq.push_back(32'h6); wq.push_back(32'h7);
        wr_burst(4'd1, 32'h600, 2, FIXED, 4'hF, OKAY);
        rexp(32'h7, OKAY); rexp(32'h7, OKAY);
        rd_burst(4'd2, 32'h600, 1, 2, FIXED, 0);

        // Reset in the middle of a 4-beat write
        aw_hs(4'd3, 32'h500, 3, 2, INCR);
        w_hs(32'h51, 4'hF, 1'b0);
        w_hs(32'h52, 4'hF, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_bvalid", bus.bvalid, 0);
            check("post_rst_wready", bus.wready, 0);
            @(posedge clk); #1;
        end
        rexp(32'h51, OKAY); rexp(32'h52, OKAY);
        rd_burst(4'd4, 32'h500, 1, 2, INCR, 0);

`ifdef AXI4_SRAM_RANGE_CHECK_EN
        // Last in-range word then one past the end
        wq.push_back(32'h1234_5678); wq.push_back(32'h8765_4321);
        wr_burst(4'd5, (MW - 1) * 4, 1, INCR, 4'hF, SLVERR);
        rexp(32'h1234_5678, OKAY); rexp(32'h0, SLVERR);
        rd_burst(4'd6, (MW - 1) * 4, 1, 2, INCR, 0);
        rexp(32'h0, SLVERR);
        rd_burst(4'd7, MW * 4, 0, 2, INCR, 0);
`else
        // INCR past the top word wraps to word 0
        wq.push_back(32'h1234_5678); wq.push_back(32'h8765_4321);
        wr_burst(4'd5, (MW - 1) * 4, 1, INCR, 4'hF, OKAY);
        rexp(32'h1234_5678, OKAY);
        rd_burst(4'd6, (MW - 1) * 4, 0, 2, INCR, 0);
        rexp(32'h8765_4321, OKAY);
        rd_burst(4'd7, 32'h0, 0, 2, INCR, 0);
`endif

        repeat (3) @(posedge clk);
        check("leftover_r", r_q.size(), 0);
        check("leftover_b", b_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
